// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them to the expected build values.
// A full check takes 3 + 2*READ_LATENCY cycles from leaving IDLE to done, plus any waitrequest stall cycles.
// Waitrequest holds the read stable; a stall of TIMEOUT_CYCLES aborts the check with timeout set.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'h533F_9A51,
   parameter int          READ_LATENCY   = 0,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        busy,
   output logic        done,
   output logic        match,
   output logic        timeout
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_ID = 3'd1,
      LAT_ID = 3'd2,
      REQ_TS = 3'd3,
      LAT_TS = 3'd4,
      CHECK  = 3'd5
   } state_t;

   // Stall count at which the read is abandoned, and the latency counter preload.
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
   localparam int         LAT_M1      = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
   localparam logic [1:0] LAT_INIT    = 2'(LAT_M1);

   state_t      state_q, state_d;
   logic [7:0]  stall_cnt_q, stall_cnt_d;
   logic [1:0]  lat_cnt_q, lat_cnt_d;
   logic        auto_pend_q, auto_pend_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        done_q, done_d;
   logic        match_q, match_d;
   logic        timeout_q, timeout_d;

   // Bus request is a pure decode of the state so it drops the cycle after acceptance or abort.
   assign avm_read    = (state_q == REQ_ID) || (state_q == REQ_TS);
   assign avm_address = (state_q == REQ_TS) || (state_q == LAT_TS);
   assign busy        = (state_q != IDLE);
   assign id_value    = id_q;
   assign ts_value    = ts_q;
   assign done        = done_q;
   assign match       = match_q;
   assign timeout     = timeout_q;

   // State register and result flags; reset aborts any check without a done pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         stall_cnt_q <= 8'd0;
         lat_cnt_q   <= 2'd0;
         auto_pend_q <= AUTO_START;
         id_q        <= 32'd0;
         ts_q        <= 32'd0;
         done_q      <= 1'b0;
         match_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         auto_pend_q <= auto_pend_d;
         id_q        <= id_d;
         ts_q        <= ts_d;
         done_q      <= done_d;
         match_q     <= match_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state logic: sequences the two reads, captures data, evaluates the result or aborts on stall.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      auto_pend_d = auto_pend_q;
      id_d        = id_q;
      ts_d        = ts_q;
      done_d      = 1'b0;
      match_d     = match_q;
      timeout_d   = timeout_q;

      case (state_q)
         IDLE: begin
            // A start arriving together with done belongs to the finished check and is dropped.
            if ((start && !done_q) || auto_pend_q) begin
               state_d     = REQ_ID;
               stall_cnt_d = 8'd0;
               auto_pend_d = 1'b0;
            end
         end

         REQ_ID, REQ_TS: begin
            if (avm_waitrequest) begin
               stall_cnt_d = stall_cnt_q + 8'd1;
               if (stall_cnt_d == TIMEOUT_LIM) begin
                  state_d   = IDLE;
                  timeout_d = 1'b1;
                  match_d   = 1'b0;
                  done_d    = 1'b1;
               end
            end else if (READ_LATENCY == 0) begin
               // Zero-latency slave: data is on the bus in the acceptance cycle.
               if (state_q == REQ_ID) begin
                  id_d        = avm_readdata;
                  state_d     = REQ_TS;
                  stall_cnt_d = 8'd0;
               end else begin
                  ts_d    = avm_readdata;
                  state_d = CHECK;
               end
            end else begin
               lat_cnt_d = LAT_INIT;
               state_d   = (state_q == REQ_ID) ? LAT_ID : LAT_TS;
            end
         end

         LAT_ID, LAT_TS: begin
            if (lat_cnt_q == 2'd0) begin
               if (state_q == LAT_ID) begin
                  id_d        = avm_readdata;
                  state_d     = REQ_TS;
                  stall_cnt_d = 8'd0;
               end else begin
                  ts_d    = avm_readdata;
                  state_d = CHECK;
               end
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end
         end

         CHECK: begin
            match_d   = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
            timeout_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: three instances cover default timing, latency/timeout, and mid-check reset.
// Expected values are hand-derived cycle counts and data constants.
// Slaves respond combinationally or through a latency pipeline driven by the bench.
module tb_sysid_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, rst_c_n;

   // Instance A: defaults, zero-wait-capable slave with bench-controlled waitrequest.
   logic        start_a, wait_a, addr_a, read_a, busy_a, done_a, match_a, tmo_a;
   logic [31:0] rdata_a, idv_a, tsv_a;
   // Instance B: AUTO_START=0, READ_LATENCY=2, TIMEOUT_CYCLES=16.
   logic        start_b, wait_b, addr_b, read_b, busy_b, done_b, match_b, tmo_b;
   logic [31:0] rdata_b, idv_b, tsv_b, slv_ts_b;
   // Instance C: AUTO_START=1, READ_LATENCY=3, non-zero expected ID, own reset.
   logic        start_c, addr_c, read_c, busy_c, done_c, match_c, tmo_c;
   logic [31:0] rdata_c, idv_c, tsv_c;

   int n_vec = 0;
   int n_err = 0;

   assign rdata_a = addr_a ? 32'h533F_9A51 : 32'h0000_0000;
   assign rdata_c = addr_c ? 32'h533F_9A51 : 32'h1234_5678;

   // Slave B returns valid data exactly two cycles after acceptance, garbage otherwise.
   logic p1_vld = 1'b0, p1_adr = 1'b0, p2_vld = 1'b0, p2_adr = 1'b0;
   always @(posedge clk) begin
      p1_vld <= read_b && !wait_b;
      p1_adr <= addr_b;
      p2_vld <= p1_vld;
      p2_adr <= p1_adr;
   end
   assign rdata_b = p2_vld ? (p2_adr ? slv_ts_b : 32'h0000_0000) : 32'hDEAD_BEEF;

   sysid_checker u_a (
      .clock(clk), .reset_n(rst_n), .start(start_a),
      .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wait_a), .avm_readdata(rdata_a),
      .id_value(idv_a), .ts_value(tsv_a), .busy(busy_a), .done(done_a), .match(match_a), .timeout(tmo_a)
   );

   sysid_checker #(.AUTO_START(1'b0), .READ_LATENCY(2), .TIMEOUT_CYCLES(16)) u_b (
      .clock(clk), .reset_n(rst_n), .start(start_b),
      .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wait_b), .avm_readdata(rdata_b),
      .id_value(idv_b), .ts_value(tsv_b), .busy(busy_b), .done(done_b), .match(match_b), .timeout(tmo_b)
   );

   sysid_checker #(.EXPECTED_ID(32'h1234_5678), .READ_LATENCY(3)) u_c (
      .clock(clk), .reset_n(rst_c_n), .start(start_c),
      .avm_address(addr_c), .avm_read(read_c), .avm_waitrequest(1'b0), .avm_readdata(rdata_c),
      .id_value(idv_c), .ts_value(tsv_c), .busy(busy_c), .done(done_c), .match(match_c), .timeout(tmo_c)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic done_of(input int which);
      case (which)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   // Waits negedge by negedge for done; cyc is the negedge count at which it was seen, -1 if never.
   task automatic wait_done(input int which, input int limit, output int cyc);
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (done_of(which)) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic pulse_start(input int which);
      case (which)
         0:       start_a = 1'b1;
         1:       start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   initial begin
      int cyc, rd, ndone;
      logic found;
      rst_n = 1'b0; rst_c_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      wait_a = 1'b0; wait_b = 1'b0;
      slv_ts_b = 32'h533F_9A50;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_flags_a", 32'({busy_a, done_a, read_a, addr_a, match_a, tmo_a}), 32'd0);
      chk("rst_id_a", idv_a, 32'd0);
      chk("rst_ts_a", tsv_a, 32'd0);
      chk("rst_flags_c", 32'({busy_c, done_c, read_c, addr_c, match_c, tmo_c}), 32'd0);

      // Auto-start after release: ID read, TS read, CHECK, done 3 cycles after leaving IDLE.
      rst_n = 1'b1; rst_c_n = 1'b1;
      @(negedge clk);
      chk("auto_req_id", 32'({read_a, addr_a, busy_a}), 32'b101);
      @(negedge clk);
      chk("auto_req_ts", 32'({read_a, addr_a, busy_a}), 32'b111);
      @(negedge clk);
      chk("auto_check", 32'({read_a, busy_a, done_a}), 32'b010);
      @(negedge clk);
      chk("auto_done", 32'({done_a, match_a, tmo_a, busy_a}), 32'b1100);
      chk("auto_ts_val", tsv_a, 32'h533F_9A51);
      @(negedge clk);
      chk("auto_done_pulse", 32'({done_a, match_a}), 32'b01);
      chk("no_auto_b", 32'(busy_b), 32'd0);

      // Five stall cycles on the ID read: request must stay put.
      wait_a = 1'b1;
      pulse_start(0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_hold", 32'({read_a, addr_a, busy_a}), 32'b101);
         @(negedge clk);
      end
      wait_a = 1'b0;
      wait_done(0, 10, cyc);
      chk("stall_done_cyc", 32'(cyc), 32'd3);
      chk("stall_result", 32'({match_a, tmo_a}), 32'b10);

      // B: AUTO_START=0, mismatching timestamp, latency 2.
      pulse_start(1);
      wait_done(1, 30, cyc);
      chk("lat2_done_cyc", 32'(cyc), 32'd7);
      chk("mis_ts_val", tsv_b, 32'h533F_9A50);
      chk("mis_match", 32'({match_b, tmo_b}), 32'b00);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done_b) ndone++;
      end
      chk("mis_single_done", 32'(ndone), 32'd0);

      // B: matching timestamp, start pulse while busy ignored, start coinciding with done ignored.
      slv_ts_b = 32'h533F_9A51;
      pulse_start(1);
      @(negedge clk);
      pulse_start(1);
      wait_done(1, 30, cyc);
      chk("busy_start_cyc", 32'(cyc), 32'd5);
      chk("lat2_match", 32'({match_b, tmo_b}), 32'b10);
      chk("lat2_ts_val", tsv_b, 32'h533F_9A51);
      pulse_start(1);
      chk("start_on_done", 32'({busy_b, done_b}), 32'b00);
      @(negedge clk);
      chk("start_on_done2", 32'(busy_b), 32'd0);

      // B: waitrequest stuck high, abort after 16 stall cycles.
      wait_b = 1'b1;
      pulse_start(1);
      rd = 0; cyc = -1;
      for (int i = 0; i < 40; i++) begin
         if (done_b) begin
            cyc = i;
            break;
         end
         if (read_b) rd++;
         @(negedge clk);
      end
      chk("tmo_read_cycles", 32'(rd), 32'd16);
      chk("tmo_done_cyc", 32'(cyc), 32'd16);
      chk("tmo_flags", 32'({tmo_b, match_b, busy_b}), 32'b100);
      chk("tmo_ts_hold", tsv_b, 32'h533F_9A51);
      @(negedge clk);
      chk("tmo_after", 32'({read_b, done_b, tmo_b}), 32'b001);
      wait_b = 1'b0;
      pulse_start(1);
      wait_done(1, 30, cyc);
      chk("recover_cyc", 32'(cyc), 32'd7);
      chk("recover_flags", 32'({match_b, tmo_b}), 32'b10);

      // C: reset during LAT_TS aborts at once, then AUTO_START reruns a full check.
      chk("c_first_match", 32'({match_c, busy_c}), 32'b10);
      pulse_start(2);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (addr_c && !read_c && busy_c) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("c_reach_lat_ts", 32'(found), 32'd1);
      chk("c_id_before_rst", idv_c, 32'h1234_5678);
      rst_c_n = 1'b0;
      #1;
      chk("c_rst_flags", 32'({busy_c, done_c, read_c, addr_c, match_c, tmo_c}), 32'd0);
      chk("c_rst_id", idv_c, 32'd0);
      chk("c_rst_ts", tsv_c, 32'd0);
      ndone = 0;
      repeat (2) begin
         @(negedge clk);
         if (done_c) ndone++;
      end
      chk("c_rst_no_done", 32'(ndone), 32'd0);
      rst_c_n = 1'b1;
      wait_done(2, 20, cyc);
      chk("c_restart_cyc", 32'(cyc), 32'd10);
      chk("c_restart_flags", 32'({match_c, tmo_c}), 32'b10);
      chk("c_restart_id", idv_c, 32'h1234_5678);
      chk("c_restart_ts", tsv_c, 32'h533F_9A51);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, the system ID value expected at word address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h533F_9A51, the build timestamp expected at word address 1.
REQ-003 SHALL have parameter READ_LATENCY, default 0, legal range 0..3: number of cycles after an accepted read before readdata is valid.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, legal range 1..255: maximum cycles a read may be stalled by waitrequest.
REQ-005 SHALL have parameter AUTO_START, default 1: when 1, one check starts automatically after reset.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: single-cycle pulse requesting a check.
REQ-009 SHALL have port avm_address, output, 1 bit: sysid word select (0 = ID, 1 = timestamp).
REQ-010 SHALL have port avm_read, output, 1 bit: Avalon-MM read request.
REQ-011 SHALL have port avm_waitrequest, input, 1 bit: slave stall; tie low for zero-wait slaves.
REQ-012 SHALL have port avm_readdata, input, 32 bits: read data from the sysid slave.
REQ-013 SHALL have port id_value, output, 32 bits: last captured ID word.
REQ-014 SHALL have port ts_value, output, 32 bits: last captured timestamp word.
REQ-015 SHALL have port busy, output, 1 bit: high while a check is in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a check completes or aborts.
REQ-017 SHALL have port match, output, 1 bit: high when the last check's ID and timestamp both equal the expected values.
REQ-018 SHALL have port timeout, output, 1 bit: high when the last check was aborted by a stall timeout.

Function
REQ-019 SHALL implement states IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, CHECK.
REQ-020 IDLE -> REQ_ID on start=1, or in the first cycle after reset release when AUTO_START=1; start is ignored in every other state.
REQ-021 In REQ_x, SHALL drive avm_read=1 with avm_address=0 (ID) or 1 (TS), holding both stable while avm_waitrequest=1.
REQ-022 A read is accepted in the cycle where avm_read=1 and avm_waitrequest=0; avm_read SHALL drop the following cycle.
REQ-023 READ_LATENCY=0: avm_readdata SHALL be captured in the acceptance cycle and LAT_x skipped; otherwise LAT_x lasts exactly READ_LATENCY cycles and data is captured in its last cycle.
REQ-024 After ID capture -> REQ_TS; after TS capture -> CHECK; CHECK lasts one cycle then -> IDLE.
REQ-025 In CHECK, match SHALL be set to (id_value==EXPECTED_ID && ts_value==EXPECTED_TS), timeout cleared, and done pulsed.
REQ-026 An 8-bit stall counter SHALL clear on entering each REQ_x and increment each cycle avm_waitrequest=1; on reaching TIMEOUT_CYCLES: avm_read=0 next cycle, timeout=1, match=0, done pulsed, -> IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE; at zero latency and no stalls a full check is 3 cycles from leaving IDLE to done.
REQ-028 id_value, ts_value, match, timeout SHALL hold their values between checks and change only in capture/CHECK/timeout cycles; captured values remain visible after a timeout.
REQ-029 A start pulse coinciding with done SHALL be ignored.

Reset
REQ-030 While reset_n=0: state=IDLE, avm_read=0, avm_address=0, id_value=0, ts_value=0, busy=0, done=0, match=0, timeout=0, stall counter=0.
REQ-031 Reset asserted mid-check SHALL abort immediately with no done pulse; after release AUTO_START governs restart.

Verification
REQ-032 Defaults, zero-wait slave returning 0 / 32'h533F9A51, reset release -> reads addr 0 then 1, done 3 cycles after leaving IDLE, match=1, timeout=0.
REQ-033 AUTO_START=0, slave timestamp 32'h533F9A50, start pulse -> ts_value=32'h533F9A50, match=0, one done pulse.
REQ-034 waitrequest high 5 cycles on ID read -> address/read stable throughout, check completes, match=1.
REQ-035 waitrequest stuck high, TIMEOUT_CYCLES=16 -> abort after 16 stall cycles, timeout=1, match=0, done pulse, busy=0.
REQ-036 READ_LATENCY=2, slave data valid 2 cycles after acceptance -> correct capture, match=1; start pulses while busy ignored.
REQ-037 reset_n pulsed low during LAT_TS -> all outputs zero at once, no done; AUTO_START=1 restarts a full check after release.
